mem_bus_arbiter: RTL

- Shares one single-ported memory bus among three requesters in the pipeline core: instruction fetch, EX-stage load and EX-stage store.
- Sequences one transaction at a time and returns fetched instructions and load data.
- Produces the stall_load / stall_store / fetch-stall signals the core's ctrl block uses to freeze the pipeline.
- Sits between the core top level and the memory/bus.

---
 rtl/mem_bus_arbiter_pkg.sv | 50 +++++
 rtl/bus_timeout_cnt.sv | 45 ++++
 rtl/mem_bus_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared types and constants for the memory bus arbiter:
//   - default bus widths (address, data, instruction)
//   - FSM state encoding (3-bit) and owner encoding (2-bit)
//   - timeout counter width
//   - helpers for the fixed-priority pick and the owner's completion state
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

  localparam int BUS_ADDR_MEM   = 64;
  localparam int BUS_DATA_MEM   = 64;
  localparam int BUS_DATA_INSTR = 32;

  // Wide enough for any TIMEOUT in 1..255.
  localparam int ARB_TMO_W = 8;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_REQ     = 3'd1,
    ARB_WAIT    = 3'd2,
    ARB_IF_DONE = 3'd3,
    ARB_LD_DONE = 3'd4,
    ARB_ST_DONE = 3'd5
  } arb_state_e;

  typedef enum logic [1:0] {
    ARB_OWN_FETCH = 2'd0,
    ARB_OWN_LOAD  = 2'd1,
    ARB_OWN_STORE = 2'd2
  } arb_owner_e;

  // Fixed priority store > load > fetch. Fetch is the fallback winner, so the
  // caller must only use the result when at least one request is present.
  function automatic arb_owner_e pick_owner(input logic st_req, input logic ld_req);
    if (st_req) return ARB_OWN_STORE;
    if (ld_req) return ARB_OWN_LOAD;
    return ARB_OWN_FETCH;
  endfunction

  // Completion state that releases the stall of the given owner.
  function automatic arb_state_e done_state(input arb_owner_e owner);
    case (owner)
      ARB_OWN_STORE: return ARB_ST_DONE;
      ARB_OWN_LOAD:  return ARB_LD_DONE;
      default:       return ARB_IF_DONE;
    endcase
  endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// -----------------------------------------------------------------------------
// bus_timeout_cnt
// Counts cycles spent waiting for a bus response and flags the last allowed
// cycle, so the arbiter can give up on a missing bus_rvalid_i.
//
// Ports:
//   clk      in  clock, rising edge
//   rst      in  synchronous, active-high reset
//   clr      in  return the count to 0 (takes precedence over en)
//   en       in  count this cycle
//   expired  out high in the cycle whose increment brings the count to TIMEOUT
// -----------------------------------------------------------------------------
module bus_timeout_cnt
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [ARB_TMO_W-1:0] LAST_CNT = ARB_TMO_W'(TIMEOUT - 1);

  logic [ARB_TMO_W-1:0] cnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Flagging one cycle early lets the FSM leave WAIT on the same edge at
  // which the count reaches TIMEOUT: TIMEOUT cycles in WAIT, not TIMEOUT+1.
  assign expired = en && (cnt == LAST_CNT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one single-ported memory bus among instruction fetch, EX-stage load
// and EX-stage store. One transaction at a time, arbitrated only in IDLE with
// fixed priority store > load > fetch, never preempted. Returns fetched
// instructions and load data, and produces the stall signals the pipeline
// control uses to freeze the core.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   instr_rd_en_i, pc_i           fetch request / address
//   instr_o, instr_vld_o          last fetched instruction / new-instruction pulse
//   stall_fetch_o                 fetch pending
//   mem_rd_en_i, addr_mem_rd_i    load request / address
//   data_mem_o                    last load data
//   mem_wr_en_i, addr_mem_wr_i,
//   data_mem_wr_i                 store request / address / data
//   stall_load_o, stall_store_o   load / store pending
//   bus_req_o, bus_we_o,
//   bus_addr_o, bus_wdata_o       bus request, write enable, address, write data
//   bus_gnt_i                     request accepted this cycle
//   bus_rvalid_i, bus_rdata_i     response / read data
//   bus_err_o                     sticky response-timeout flag
// -----------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int          ADDR_W  = BUS_ADDR_MEM,
  parameter int          DATA_W  = BUS_DATA_MEM,
  parameter int          INSTR_W = BUS_DATA_INSTR,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               instr_rd_en_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_vld_o,
  output logic               stall_fetch_o,

  input  logic               mem_rd_en_i,
  input  logic [ADDR_W-1:0]  addr_mem_rd_i,
  output logic [DATA_W-1:0]  data_mem_o,
  input  logic               mem_wr_en_i,
  input  logic [ADDR_W-1:0]  addr_mem_wr_i,
  input  logic [DATA_W-1:0]  data_mem_wr_i,
  output logic               stall_load_o,
  output logic               stall_store_o,

  output logic               bus_req_o,
  output logic               bus_we_o,
  output logic [ADDR_W-1:0]  bus_addr_o,
  output logic [DATA_W-1:0]  bus_wdata_o,
  input  logic               bus_gnt_i,
  input  logic               bus_rvalid_i,
  input  logic [DATA_W-1:0]  bus_rdata_i,
  output logic               bus_err_o
);

  arb_state_e          state;
  arb_state_e          state_nxt;
  arb_owner_e          owner;
  arb_owner_e          owner_sel;

  logic [ADDR_W-1:0]   addr_sel;
  logic                any_req;
  logic                arb_take;

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                we_q;
  logic [INSTR_W-1:0]  instr_q;
  logic [DATA_W-1:0]   data_q;
  logic                err_q;

  logic                tmo_clr;
  logic                tmo_en;
  logic                tmo_expired;

  // ---------------------------------------------------------------------------
  // Arbitration: only consulted in IDLE; the winner's request is captured in
  // registers so the core may change its inputs while the bus is busy.
  // ---------------------------------------------------------------------------
  assign any_req   = instr_rd_en_i | mem_rd_en_i | mem_wr_en_i;
  assign owner_sel = pick_owner(mem_wr_en_i, mem_rd_en_i);
  assign arb_take  = (state == ARB_IDLE) && any_req;

  always_comb begin
    case (owner_sel)
      ARB_OWN_STORE: addr_sel = addr_mem_wr_i;
      ARB_OWN_LOAD:  addr_sel = addr_mem_rd_i;
      default:       addr_sel = pc_i;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt gets its hold value before the case so that no path
  // leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (any_req) state_nxt = ARB_REQ;
      end
      ARB_REQ: begin
        if (bus_gnt_i) state_nxt = ARB_WAIT;
      end
      ARB_WAIT: begin
        // A timeout completes the transaction like a response would, so a
        // silent bus can never deadlock the pipeline.
        if (bus_rvalid_i || tmo_expired) state_nxt = done_state(owner);
      end
      default: begin
        // All DONE states last exactly one cycle; the same source must win
        // arbitration again from IDLE to be served again.
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response timeout: runs only while waiting for the response, so grant
  // backpressure in REQ never eats into the response budget.
  // ---------------------------------------------------------------------------
  assign tmo_en  = (state == ARB_WAIT);
  assign tmo_clr = (state != ARB_WAIT);

  bus_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_bus_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: every register here is reset, not only the control state, because
  // the bus outputs and returned data must read 0 straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner   <= ARB_OWN_FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      instr_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (arb_take) begin
        owner   <= owner_sel;
        addr_q  <= addr_sel;
        we_q    <= (owner_sel == ARB_OWN_STORE);
        wdata_q <= (owner_sel == ARB_OWN_STORE) ? data_mem_wr_i : '0;
      end

      // Responses are only accepted in WAIT; a stray bus_rvalid_i in any
      // other state (including one left over from before a reset) is dropped.
      if (state == ARB_WAIT) begin
        if (bus_rvalid_i) begin
          case (owner)
            ARB_OWN_FETCH: instr_q <= bus_rdata_i[INSTR_W-1:0];
            ARB_OWN_LOAD:  data_q  <= bus_rdata_i;
            default:       ;
          endcase
        end else if (tmo_expired) begin
          err_q <= 1'b1;
          case (owner)
            ARB_OWN_FETCH: instr_q <= '0;
            ARB_OWN_LOAD:  data_q  <= '0;
            default:       ;
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus_req_o   = (state == ARB_REQ);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_err_o   = err_q;

  assign instr_o     = instr_q;
  assign data_mem_o  = data_q;
  assign instr_vld_o = (state == ARB_IF_DONE);

  // A request's stall drops exactly in its own DONE cycle; a request that is
  // still queued behind another owner keeps stalling throughout.
  assign stall_fetch_o = ~rst & instr_rd_en_i & (state != ARB_IF_DONE);
  assign stall_load_o  = ~rst & mem_rd_en_i   & (state != ARB_LD_DONE);
  assign stall_store_o = ~rst & mem_wr_en_i   & (state != ARB_ST_DONE);

endmodule
